// File: rtl/decay_sweep_controller.sv
// Timestep-driven sweep controller: initialises a potential store, then on every
// timestep tick streams each active neuron through a shared decay unit and back.
module decay_sweep_controller #(
    parameter int          NEURONS        = 30,
    parameter int          ADDR_W         = 5,
    parameter logic [31:0] INIT_POTENTIAL = 32'h41DED852
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [15:0]       timestep_len,
    input  logic [ADDR_W-1:0] num_neurons,
    input  logic [3:0]        decay_rate,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              dec_req,
    output logic [31:0]       dec_potential,
    output logic [3:0]        dec_rate,
    input  logic              dec_ack,
    input  logic [31:0]       dec_result,
    output logic              tick,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [2:0]        fsm_state
);

    // Decay handshake: dec_req is held with dec_potential/dec_rate stable until the
    // first cycle where dec_ack=1; dec_result is captured in that same cycle.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        WAIT_TICK = 3'd2,
        READ      = 3'd3,
        LOAD      = 3'd4,
        REQ       = 3'd5,
        WRITE     = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(NEURONS - 1);
    localparam logic [ADDR_W-1:0] MAX_COUNT = ADDR_W'(NEURONS);

    state_t            state;
    logic [15:0]       cnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] count_lat;
    logic [3:0]        rate_lat;
    logic [31:0]       pot;
    logic [31:0]       result;
    logic              done_zero;

    logic              sweeping;
    logic              run;
    logic              tick_now;
    logic              last_neuron;
    logic [ADDR_W-1:0] n_clamped;

    assign sweeping    = (state == READ) || (state == LOAD) || (state == REQ) || (state == WRITE);
    assign run         = start && (timestep_len != 16'd0) && ((state == WAIT_TICK) || sweeping);
    // >= rather than == so a shrinking timestep_len cannot strand the counter above the wrap point
    assign tick_now    = run && (cnt >= timestep_len - 16'd1);
    assign last_neuron = (idx == count_lat - ADDR_W'(1));
    assign n_clamped   = (num_neurons > MAX_COUNT) ? MAX_COUNT : num_neurons;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            count_lat <= '0;
            rate_lat  <= '0;
            pot       <= '0;
            result    <= '0;
            done_zero <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done_zero <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
            end else if (run) begin
                cnt <= tick_now ? 16'd0 : cnt + 16'd1;
            end

            if (tick_now && sweeping) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= INIT;
                    end
                end
                INIT: begin
                    if (idx == LAST_SLOT) begin
                        idx   <= '0;
                        state <= start ? WAIT_TICK : IDLE;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                WAIT_TICK: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (tick_now) begin
                        rate_lat  <= decay_rate;
                        count_lat <= n_clamped;
                        idx       <= '0;
                        if (n_clamped == '0) begin
                            done_zero <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= LOAD;
                LOAD: begin
                    pot   <= rd_data;
                    state <= REQ;
                end
                REQ: begin
                    if (dec_ack) begin
                        result <= dec_result;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (last_neuron) begin
                        state <= start ? WAIT_TICK : IDLE;
                    end else begin
                        idx   <= idx + ADDR_W'(1);
                        state <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so reset drives every one of them to 0.
    assign rd_addr       = (state == READ) ? idx : '0;
    assign wr_en         = (state == INIT) || (state == WRITE);
    assign wr_addr       = wr_en ? idx : '0;
    assign wr_data       = (state == INIT) ? INIT_POTENTIAL : ((state == WRITE) ? result : 32'd0);
    assign dec_req       = (state == REQ);
    assign dec_potential = dec_req ? pot : 32'd0;
    assign dec_rate      = dec_req ? rate_lat : 4'd0;
    assign tick          = tick_now;
    assign busy          = sweeping;
    assign done          = done_zero || ((state == WRITE) && last_neuron);
    assign fsm_state     = state;

endmodule

// File: tb/tb_decay_sweep_controller.sv
// Directed bench for decay_sweep_controller: table of sweep scenarios plus
// hand-written start/stop and reset-during-handshake sequences.
module tb_decay_sweep_controller;

    localparam logic [31:0] INIT_P = 32'h41DED852;
    localparam int          NSLOT  = 30;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] timestep_len = 16'd0;
    logic [4:0]  num_neurons = 5'd0;
    logic [3:0]  decay_rate = 4'd0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        dec_req;
    logic [31:0] dec_potential;
    logic [3:0]  dec_rate;
    logic        dec_ack;
    logic [31:0] dec_result;
    logic        tick, busy, done, overrun;
    logic [2:0]  fsm_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_delay = 0;
    int req_age = 0;
    logic [31:0] mem [0:31];

    decay_sweep_controller dut (
        .CLK(CLK), .RST(RST), .start(start), .timestep_len(timestep_len),
        .num_neurons(num_neurons), .decay_rate(decay_rate),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dec_req(dec_req), .dec_potential(dec_potential), .dec_rate(dec_rate),
        .dec_ack(dec_ack), .dec_result(dec_result),
        .tick(tick), .busy(busy), .done(done), .overrun(overrun), .fsm_state(fsm_state)
    );

    // ---- clock / models ----
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
        req_age <= (dec_req && !dec_ack) ? req_age + 1 : 0;
    end

    assign dec_ack    = dec_req && (req_age >= ack_delay);
    assign dec_result = dec_potential - {28'd0, dec_rate};

    typedef struct {
        logic [15:0] len;
        logic [4:0]  n;
        int          delay;
        logic [3:0]  rate;
        int          exp_n;
        int          exp_done;
        logic        exp_ovr;
    } vec_t;

    vec_t vecs [6];

    // ---- checking helpers ----
    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic nz;
        nz = ({rd_addr, wr_en, wr_addr, wr_data, dec_req, dec_potential, dec_rate,
               tick, busy, done, overrun} != '0);
        check(name, nz, 0);
    endtask

    task automatic apply_reset();
        RST = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge CLK);
        check_outputs_zero("reset_outputs");
        check("reset_state", fsm_state, 0);
        RST = 1'b0;
    endtask

    // Expects start=1: 30 back-to-back INIT writes beginning the cycle after entry.
    task automatic do_init(output int t_last);
        int nw, bad, cyc0;
        nw = 0; bad = 0; cyc0 = cyc; t_last = -1000;
        for (int c = 0; c < 45 && nw < NSLOT; c++) begin
            @(negedge CLK);
            if (wr_en) begin
                if (wr_addr != 5'(nw) || wr_data != INIT_P) bad++;
                if (nw == 0 && cyc != cyc0 + 1) bad++;
                if (nw > 0 && cyc != t_last + 1) bad++;
                t_last = cyc;
                nw++;
            end
        end
        check("init_writes", nw, NSLOT);
        check("init_bad", bad, 0);
        @(negedge CLK);
        check("init_to_wait", fsm_state, 2);
    endtask

    task automatic wait_tick(input int max_cyc, output int t);
        t = -100000;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge CLK);
            if (tick) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("tick_timeout", 0, 1);
    endtask

    task automatic run_vector(input vec_t v);
        int t0, t_last, nw, bad_w, reqs, bad_req, t_done, t_tick2;
        logic busy1;
        apply_reset();
        timestep_len = v.len; num_neurons = v.n; decay_rate = v.rate; ack_delay = v.delay;
        start = 1'b1;
        do_init(t_last);
        wait_tick(int'(v.len) + 5, t0);
        check("first_tick_gap", t0 - t_last, v.len);
        nw = 0; bad_w = 0; reqs = 0; bad_req = 0; t_done = -100000; t_tick2 = -100000; busy1 = 1'b0;
        for (int c = 1; c <= 400 && t_done < 0; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                busy1 = busy;
                decay_rate = ~v.rate;   // latched values must survive input changes
                num_neurons = 5'd2;
            end
            if (wr_en) begin
                if (wr_addr != 5'(nw) || wr_data != INIT_P - {28'd0, v.rate} ||
                    cyc != t0 + (nw + 1) * (4 + v.delay)) bad_w++;
                nw++;
            end
            if (dec_req) begin
                reqs++;
                if (wr_en || dec_potential != INIT_P || dec_rate != v.rate) bad_req++;
            end
            if (tick && t_tick2 < 0) t_tick2 = cyc;
            if (done) t_done = cyc;
        end
        check("done_gap", t_done - t0, v.exp_done);
        check("sweep_writes", nw, v.exp_n);
        check("sweep_write_bad", bad_w, 0);
        check("req_cycles", reqs, v.exp_n * (1 + v.delay));
        check("req_bad", bad_req, 0);
        check("busy_after_tick", busy1, (v.exp_n > 0));
        check("overrun", overrun, v.exp_ovr);
        if (t_tick2 < 0) wait_tick(int'(v.len) + 5, t_tick2);
        check("tick_period", t_tick2 - t0, v.len);
        repeat (30) @(negedge CLK);
        check("overrun_sticky", overrun, v.exp_ovr);
    endtask

    initial begin
        int t0, t1, t_last, nw, t_done, stray;
        logic found;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;

        //         len     n      dly rate  exp_n done ovr
        vecs[0] = '{16'd200, 5'd3,  0, 4'h1, 3,  12,  1'b0};
        vecs[1] = '{16'd100, 5'd5,  2, 4'h2, 5,  30,  1'b0};
        vecs[2] = '{16'd50,  5'd0,  0, 4'h4, 0,  1,   1'b0};
        vecs[3] = '{16'd200, 5'd31, 0, 4'h8, 30, 120, 1'b0};
        vecs[4] = '{16'd8,   5'd30, 0, 4'h3, 30, 120, 1'b1};
        vecs[5] = '{16'd60,  5'd7,  1, 4'h1, 7,  35,  1'b0};

        for (int i = 0; i < 6; i++) run_vector(vecs[i]);

        // Reset in the middle of the handshake for neuron 7, after an overrun.
        apply_reset();
        timestep_len = 16'd40; num_neurons = 5'd30; decay_rate = 4'h1; ack_delay = 5;
        start = 1'b1;
        do_init(t_last);
        wait_tick(45, t0);
        nw = 0; found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge CLK);
            if (wr_en) nw++;
            if (nw == 7 && dec_req) found = 1'b1;
        end
        check("reach_req_idx7", found, 1);
        check("overrun_before_reset", overrun, 1);
        #1 RST = 1'b1;
        #1 check_outputs_zero("async_reset_outputs");
        check("async_reset_state", fsm_state, 0);
        @(negedge CLK);
        RST = 1'b0;
        do_init(t_last);

        // start dropped mid-sweep: sweep completes, then IDLE with counter cleared.
        apply_reset();
        timestep_len = 16'd20; num_neurons = 5'd4; decay_rate = 4'h2; ack_delay = 0;
        start = 1'b1;
        do_init(t_last);
        wait_tick(25, t0);
        @(posedge CLK);
        #1 start = 1'b0;
        nw = 0; t_done = -100000;
        for (int c = 0; c < 40 && t_done < 0; c++) begin
            @(negedge CLK);
            if (wr_en) nw++;
            if (done) t_done = cyc;
        end
        check("stop_sweep_writes", nw, 4);
        check("stop_done_gap", t_done - t0, 16);
        @(negedge CLK);
        check("stop_to_idle", fsm_state, 0);
        stray = 0;
        repeat (50) begin
            @(negedge CLK);
            if (tick || wr_en || dec_req) stray++;
        end
        check("idle_quiet", stray, 0);

        // Restart reruns INIT; start=0 in WAIT_TICK leaves next cycle.
        start = 1'b1;
        do_init(t_last);
        start = 1'b0;
        @(negedge CLK);
        check("wait_stop_idle", fsm_state, 0);
        start = 1'b1;
        do_init(t_last);
        wait_tick(25, t1);
        check("restart_tick_gap", t1 - t_last, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
